uart_rx_8x: RTL and testbench

Asynchronous serial receiver (8N1, LSB first) that recovers bytes from the `rx` line and is the receive-side counterpart to the UART transmit path. It runs entirely on the system clock, using an internal clock-enable tick at 8x the baud rate rather than a derived clock. It synchronises the line, detects and validates the start bit, and samples each bit at its centre. It presents each byte with a one-cycle valid strobe, plus error strobes.

---
 rtl/uart_rx_8x.sv | 208 ++++++++++++++++++++
 tb/tb_uart_rx_8x.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_8x.sv
// -----------------------------------------------------------------------------
// uart_rx_8x
//   Asynchronous serial receiver, 8N1 (or 8E1), LSB first, 8x oversampled.
//   All logic runs on clk; a divider produces a one-cycle clock-enable tick
//   at 8x the baud rate. The line is synchronised, the start bit is validated
//   at its centre, and every following bit is sampled at its centre.
//
//   Build option:
//     UART_RX_PARITY_EN  when defined, one even-parity bit is expected between
//                        data bit 7 and the stop bit and parity_err is live.
//                        When undefined, the PARITY state is not built and
//                        parity_err is tied to 0.
//
//   Ports:
//     clk          in   system clock, rising edge
//     rst          in   synchronous, active-high reset
//     rx           in   asynchronous serial line, idle high
//     data[7:0]    out  last received byte, held until the next frame ends
//     valid        out  one-cycle strobe, data is a correctly framed byte
//     framing_err  out  one-cycle strobe, stop bit sampled low
//     parity_err   out  one-cycle strobe, parity mismatch
//     busy         out  high whenever the receiver is not idle
//
//   Handshake: there is no back-pressure. valid / framing_err / parity_err are
//   single-cycle strobes with no ready; a consumer must capture data in the
//   cycle valid is high or re-read it before the next frame completes.
// -----------------------------------------------------------------------------
module uart_rx_8x #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       framing_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int DIV = CLK_HZ / (BAUD * 8);
    localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

    if (DIV < 2 || DIV > 65535) begin : g_bad_div
        $error("uart_rx_8x: CLK_HZ/(BAUD*8) must lie in 2..65535");
    end
    if (OVERSAMPLE != 8) begin : g_bad_os
        $error("uart_rx_8x: only OVERSAMPLE = 8 is supported");
    end

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t      state_q, state_d;
    logic        sync1_q, rx_s_q;
    logic [1:0]  settle_q;
    logic [15:0] div_q;
    logic [2:0]  sub_q;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  data_q, data_d;
    logic        armed_q, armed_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        tick, tick_last, clr_div, clr_sub;
`ifdef UART_RX_PARITY_EN
    logic        par_q, par_d;
    logic        perr_q, perr_d;
`endif

    assign tick      = (div_q == DIV_LAST);
    // Eighth tick of a bit period: the centre of the next bit, counted from
    // the start-bit centre.
    assign tick_last = tick && (sub_q == 3'd7);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b1;
            rx_s_q   <= 1'b1;
            settle_q <= 2'b00;
            div_q    <= '0;
            sub_q    <= '0;
            state_q  <= IDLE;
            armed_q  <= 1'b0;
            idx_q    <= '0;
            shreg_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q    <= 1'b0;
            perr_q   <= 1'b0;
`endif
        end else begin
            sync1_q  <= rx;
            rx_s_q   <= sync1_q;
            settle_q <= {settle_q[0], 1'b1};
            if (clr_div || tick) div_q <= '0;
            else                 div_q <= div_q + 16'd1;
            if (clr_sub)   sub_q <= '0;
            else if (tick) sub_q <= sub_q + 3'd1;
            state_q  <= state_d;
            armed_q  <= armed_d;
            idx_q    <= idx_d;
            shreg_q  <= shreg_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q    <= par_d;
            perr_q   <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        clr_div = 1'b0;
        clr_sub = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // The synchroniser resets to 1; that reset value must not
                // count as a line high, or a line held low across reset
                // would look like a fresh start edge. settle_q[1] marks the
                // first rx_s value that came from the real line.
                if (rx_s_q && settle_q[1]) armed_d = 1'b1;
                if (armed_q && !rx_s_q) begin
                    state_d = START;
                    armed_d = 1'b0;
                    clr_div = 1'b1;
                    clr_sub = 1'b1;
                    idx_d   = '0;
                end
            end
            START: begin
                if (tick && (sub_q == 3'd3)) begin
                    if (rx_s_q) begin
                        state_d = IDLE;
                    end else begin
                        clr_sub = 1'b1;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (tick_last) begin
                    shreg_d[idx_q] = rx_s_q;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick_last) begin
                    par_d   = rx_s_q;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (tick_last) begin
                    data_d  = shreg_q;
                    ferr_d  = !rx_s_q;
`ifdef UART_RX_PARITY_EN
                    perr_d  = ^{shreg_q, par_q};
                    valid_d = rx_s_q && !(^{shreg_q, par_q});
`else
                    valid_d = rx_s_q;
`endif
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign data        = data_q;
    assign valid       = valid_q;
    assign framing_err = ferr_q;
    assign busy        = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err  = perr_q;
`else
    assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_8x.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_8x
//   Bench for uart_rx_8x at DIV = 20 (160 clock cycles per bit). A line-level
//   driver serialises frames; expected strobes (byte, kind, arrival cycle) are
//   queued when a frame is driven and checked when the receiver strobes.
// -----------------------------------------------------------------------------
module tb_uart_rx_8x;

    localparam int CLK_HZ = 1_600_000;
    localparam int BAUD   = 10_000;
    localparam int DIV    = 20;
    localparam int BIT    = 8 * DIV;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS     = 11;
    localparam int STOP_TICK = 84;
`else
    localparam int NBITS     = 10;
    localparam int STOP_TICK = 76;
`endif
    localparam int FRAME = NBITS * BIT;
    // Driving the start bit right after edge k: two synchroniser edges plus
    // the start-detect edge give T0 at edge k+3; the strobe follows the stop
    // sample STOP_TICK*DIV edges later.
    localparam int LAT = 3 + STOP_TICK * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       valid, framing_err, parity_err, busy;

    uart_rx_8x #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .data        (data),
        .valid       (valid),
        .framing_err (framing_err),
        .parity_err  (parity_err),
        .busy        (busy)
    );

    // ---- clock / reset -----------------------------------------------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    // ---- scoreboard --------------------------------------------------------
    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
        int         at;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (valid || framing_err || parity_err) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: valid=%0b ferr=%0b perr=%0b data=0x%0h at cycle %0d, none expected",
                         valid, framing_err, parity_err, data, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("strobe_data",  int'(data),        int'(mon_e.d));
                chk("strobe_valid", int'(valid),       int'(!mon_e.fe && !mon_e.pe));
                chk("strobe_ferr",  int'(framing_err), int'(mon_e.fe));
                chk("strobe_perr",  int'(parity_err),  int'(mon_e.pe));
                chk("strobe_cycle", cyc,               mon_e.at);
            end
        end
    end

    task automatic expect_frame(input logic [7:0] d, input logic fe, input logic pe);
        exp_t e;
        e.d  = d;
        e.fe = fe;
        e.pe = pe;
        e.at = cyc + LAT;
        exp_q.push_back(e);
    endtask

    // ---- driver ------------------------------------------------------------
    // Serialises one frame; rst_at >= 0 pulses reset for one cycle at that
    // offset into the frame and checks the outputs right after it.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input int rst_at, output int busy_cnt);
        logic [10:0] bits;
        bits      = 11'h7ff;
        bits[0]   = 1'b0;
        bits[8:1] = d;
`ifdef UART_RX_PARITY_EN
        bits[9]   = par;
        bits[10]  = stop;
`else
        bits[9]   = stop;
        if (par) bits[10] = 1'b1;
`endif
        busy_cnt = 0;
        for (int c = 0; c < FRAME; c++) begin
            rx  = bits[c / BIT];
            rst = (c == rst_at);
            step();
            if (busy) busy_cnt++;
            if (c == rst_at) begin
                chk("rst_mid_data",  int'(data),        0);
                chk("rst_mid_valid", int'(valid),       0);
                chk("rst_mid_ferr",  int'(framing_err), 0);
                chk("rst_mid_perr",  int'(parity_err),  0);
                chk("rst_mid_busy",  int'(busy),        0);
            end
        end
        rst = 1'b0;
    endtask

    // ---- stimulus ----------------------------------------------------------
    typedef struct {
        logic [7:0] d;
        logic       par;
        logic       stop;
        int         gap;
        logic       exp_fe;
        logic       exp_pe;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t mk(input logic [7:0] d, input logic par, input logic stop,
                                input int gap, input logic fe, input logic pe);
        vec_t v;
        v.d = d; v.par = par; v.stop = stop; v.gap = gap; v.exp_fe = fe; v.exp_pe = pe;
        return v;
    endfunction

    initial begin
        int bcnt;
        int k;
        logic [7:0] r;

        // Single byte, then back-to-back run with no idle gap, then random.
        vecs.push_back(mk(8'hA5, ^8'hA5, 1'b1, 200, 1'b0, 1'b0));
        vecs.push_back(mk(8'h00, 1'b0,   1'b1, 200, 1'b0, 1'b0));
        vecs.push_back(mk(8'hFF, 1'b0,   1'b1, 0,   1'b0, 1'b0));
        vecs.push_back(mk(8'h3C, 1'b0,   1'b1, 0,   1'b0, 1'b0));
        for (int i = 0; i < 4; i++) begin
            r = 8'($urandom_range(0, 255));
            vecs.push_back(mk(r, ^r, 1'b1, $urandom_range(0, 50), 1'b0, 1'b0));
        end
`ifdef UART_RX_PARITY_EN
        vecs.push_back(mk(8'h07, 1'b1, 1'b1, 100, 1'b0, 1'b0));
        vecs.push_back(mk(8'h07, 1'b0, 1'b1, 100, 1'b0, 1'b1));
`endif

        // Reset state
        rst = 1'b1;
        rx  = 1'b1;
        step();
        step();
        chk("reset_data",  int'(data),        0);
        chk("reset_valid", int'(valid),       0);
        chk("reset_ferr",  int'(framing_err), 0);
        chk("reset_perr",  int'(parity_err),  0);
        chk("reset_busy",  int'(busy),        0);
        rst = 1'b0;

        // Table-driven frames
        foreach (vecs[i]) begin
            idle(vecs[i].gap);
            expect_frame(vecs[i].d, vecs[i].exp_fe, vecs[i].exp_pe);
            send_frame(vecs[i].d, vecs[i].par, vecs[i].stop, -1, bcnt);
            chk("busy_cycles", bcnt, STOP_TICK * DIV);
        end

        // Glitch: 40 cycles low must be rejected at the start-bit centre.
        idle(200);
        k  = cyc;
        rx = 1'b0;
        for (int i = 0; i < 40; i++) step();
        rx = 1'b1;
        while (cyc < k + 82) step();
        chk("glitch_busy_hi", int'(busy), 1);
        step();
        chk("glitch_busy_lo", int'(busy), 0);
        idle(300);

        // Framing error, then a break: exactly one framing_err.
        expect_frame(8'h55, 1'b1, 1'b0);
        send_frame(8'h55, ^8'h55, 1'b0, -1, bcnt);
        chk("ferr_busy_cycles", bcnt, STOP_TICK * DIV);
        rx = 1'b0;
        for (int i = 0; i < 3000; i++) step();
        chk("break_busy", int'(busy), 0);
        idle(300);
        expect_frame(8'h12, 1'b0, 1'b0);
        send_frame(8'h12, ^8'h12, 1'b1, -1, bcnt);

        // Reset during data bit 3 of 0x81, then 0x42.
        idle(200);
        send_frame(8'h81, ^8'h81, 1'b1, 4 * BIT + 60, bcnt);
        idle(200);
        expect_frame(8'h42, 1'b0, 1'b0);
        send_frame(8'h42, ^8'h42, 1'b1, -1, bcnt);

        // Drain the scoreboard with a bounded wait.
        for (int w = 0; w < 3000 && exp_q.size() > 0; w++) step();
        idle(200);
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_strobe: data=0x%0h due at cycle %0d never seen", mon_e.d, mon_e.at);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
